// File: rtl/door_pad_encoder.sv
// Door pressure-pad sequence encoder: synchronizes and debounces two pads, then decodes
// entry/exit passages. Define DOOR_PAD_ERRCNT_EN to add the saturating err_count output.
module door_pad_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_outer,
  input  logic       pad_inner,
  output logic       pressure_in,
  output logic       pressure_out,
  output logic       busy,
  output logic       seq_error
`ifdef DOOR_PAD_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMER_W = 16;
  localparam logic [CNT_W-1:0]   DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT  = TIMER_W'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_O1       = 3'd1;
  localparam logic [2:0] S_OB       = 3'd2;
  localparam logic [2:0] S_O2       = 3'd3;
  localparam logic [2:0] S_I1       = 3'd4;
  localparam logic [2:0] S_IB       = 3'd5;
  localparam logic [2:0] S_I2       = 3'd6;
  localparam logic [2:0] S_WAIT_CLR = 3'd7;

  logic [1:0]         sync_outer, sync_inner;
  logic               deb_outer, deb_inner;
  logic [CNT_W-1:0]   cnt_outer, cnt_inner;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         state, state_next;
  logic [1:0]         pads;
  logic               in_c, out_c, err_c, illegal;

  // Two-flop synchronizers for the asynchronous pads
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_outer <= 2'b00;
      sync_inner <= 2'b00;
    end else begin
      sync_outer <= {sync_outer[0], pad_outer};
      sync_inner <= {sync_inner[0], pad_inner};
    end
  end

  // Debouncers: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_outer <= 1'b0;
      cnt_outer <= '0;
    end else if (sync_outer[1] == deb_outer) begin
      cnt_outer <= '0;
    end else if (cnt_outer == DEB_LAST) begin
      deb_outer <= sync_outer[1];
      cnt_outer <= '0;
    end else begin
      cnt_outer <= cnt_outer + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_inner <= 1'b0;
      cnt_inner <= '0;
    end else if (sync_inner[1] == deb_inner) begin
      cnt_inner <= '0;
    end else if (cnt_inner == DEB_LAST) begin
      deb_inner <= sync_inner[1];
      cnt_inner <= '0;
    end else begin
      cnt_inner <= cnt_inner + CNT_W'(1);
    end
  end

  // Sequence timer: held at zero in IDLE, saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) begin
      timer <= '0;
    end else if (timer != '1) begin
      timer <= timer + TIMER_W'(1);
    end
  end

  assign pads = {deb_outer, deb_inner};

  // Next-state decode; a timeout overrides any same-cycle legal move
  always_comb begin
    state_next = state;
    in_c       = 1'b0;
    out_c      = 1'b0;
    err_c      = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_IDLE:
        case (pads)
          2'b10:   state_next = S_O1;
          2'b01:   state_next = S_I1;
          2'b11:   illegal = 1'b1;
          default: state_next = S_IDLE;
        endcase
      S_O1:
        case (pads)
          2'b10:   state_next = S_O1;
          2'b11:   state_next = S_OB;
          2'b00:   state_next = S_IDLE;
          default: illegal = 1'b1;
        endcase
      S_OB:
        case (pads)
          2'b11:   state_next = S_OB;
          2'b01:   state_next = S_O2;
          2'b10:   state_next = S_O1;
          default: illegal = 1'b1;
        endcase
      S_O2:
        case (pads)
          2'b01:   state_next = S_O2;
          2'b11:   state_next = S_OB;
          2'b00: begin
            state_next = S_IDLE;
            in_c       = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      S_I1:
        case (pads)
          2'b01:   state_next = S_I1;
          2'b11:   state_next = S_IB;
          2'b00:   state_next = S_IDLE;
          default: illegal = 1'b1;
        endcase
      S_IB:
        case (pads)
          2'b11:   state_next = S_IB;
          2'b10:   state_next = S_I2;
          2'b01:   state_next = S_I1;
          default: illegal = 1'b1;
        endcase
      S_I2:
        case (pads)
          2'b10:   state_next = S_I2;
          2'b11:   state_next = S_IB;
          2'b00: begin
            state_next = S_IDLE;
            out_c      = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      S_WAIT_CLR:
        if (pads == 2'b00) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if ((state != S_IDLE) && (state != S_WAIT_CLR) && (timer >= TIMEOUT)) begin
      state_next = S_WAIT_CLR;
      in_c       = 1'b0;
      out_c      = 1'b0;
      err_c      = 1'b1;
    end else if (illegal) begin
      state_next = S_WAIT_CLR;
      err_c      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pressure_in  <= 1'b0;
      pressure_out <= 1'b0;
      seq_error    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      pressure_in  <= in_c;
      pressure_out <= out_c;
      seq_error    <= err_c;
      busy         <= (state_next != S_IDLE);
    end
  end

`ifdef DOOR_PAD_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (err_c && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_door_pad_encoder.sv
// Bench for door_pad_encoder: cycle-level behavioural model plus directed passage scenarios.
module tb_door_pad_encoder;

  localparam int DEB = 4;
  localparam int TO  = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pad_outer = 1'b0;
  logic pad_inner = 1'b0;
  logic pressure_in, pressure_out, busy, seq_error;
`ifdef DOOR_PAD_ERRCNT_EN
  logic [7:0] err_count;
`endif

  always #5 clk = ~clk;

  door_pad_encoder #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .pad_outer(pad_outer),
    .pad_inner(pad_inner),
    .pressure_in(pressure_in),
    .pressure_out(pressure_out),
    .busy(busy),
    .seq_error(seq_error)
`ifdef DOOR_PAD_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle time %0t)", name, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_O1, M_OB, M_O2, M_I1, M_IB, M_I2, M_WAIT} mstate_t;

  // Passage rules as a table of legal moves; anything else is an illegal sequence.
  function automatic void step(input mstate_t s, input bit o, input bit i, input bit tmo,
                               output mstate_t n, output bit pin, output bit pout,
                               output bit perr);
    bit [1:0] p;
    p = {o, i};
    n = s; pin = 0; pout = 0; perr = 0;
    if (tmo) begin
      n = M_WAIT; perr = 1;
      return;
    end
    case (s)
      M_IDLE: if (p == 2'b10) n = M_O1; else if (p == 2'b01) n = M_I1;
              else if (p == 2'b11) begin n = M_WAIT; perr = 1; end
      M_O1:   if (p == 2'b11) n = M_OB; else if (p == 2'b00) n = M_IDLE;
              else if (p == 2'b01) begin n = M_WAIT; perr = 1; end
      M_OB:   if (p == 2'b01) n = M_O2; else if (p == 2'b10) n = M_O1;
              else if (p == 2'b00) begin n = M_WAIT; perr = 1; end
      M_O2:   if (p == 2'b11) n = M_OB; else if (p == 2'b00) begin n = M_IDLE; pin = 1; end
              else if (p == 2'b10) begin n = M_WAIT; perr = 1; end
      M_I1:   if (p == 2'b11) n = M_IB; else if (p == 2'b00) n = M_IDLE;
              else if (p == 2'b10) begin n = M_WAIT; perr = 1; end
      M_IB:   if (p == 2'b10) n = M_I2; else if (p == 2'b01) n = M_I1;
              else if (p == 2'b00) begin n = M_WAIT; perr = 1; end
      M_I2:   if (p == 2'b11) n = M_IB; else if (p == 2'b00) begin n = M_IDLE; pout = 1; end
              else if (p == 2'b01) begin n = M_WAIT; perr = 1; end
      default: if (p == 2'b00) n = M_IDLE;
    endcase
  endfunction

  function automatic int count_diff(input bit q[$], input bit v);
    int c = 0;
    foreach (q[k]) if (q[k] != v) c++;
    return c;
  endfunction

  int      cyc = 0;
  bit      started = 0;
  bit      rd1o, rd2o, rd1i, rd2i, m_do, m_di;
  bit      hist_o[$], hist_i[$];
  mstate_t ms = M_IDLE, ns;
  int      age = 0, m_errs = 0;
  bit      e_in, e_out, e_err, e_busy, pin, pout, perr, tmo;

  // Model advances on every rising edge from the levels the DUT also sees
  always @(posedge clk) begin
    cyc = cyc + 1;
    started = 1;
    if (reset) begin
      rd1o = 0; rd2o = 0; rd1i = 0; rd2i = 0; m_do = 0; m_di = 0;
      hist_o.delete(); hist_i.delete();
      ms = M_IDLE; age = 0; m_errs = 0;
      e_in = 0; e_out = 0; e_err = 0; e_busy = 0;
    end else begin
      tmo = (ms != M_IDLE) && (ms != M_WAIT) && (age >= TO);
      step(ms, m_do, m_di, tmo, ns, pin, pout, perr);
      age = (ms == M_IDLE) ? 0 : ((age < 65535) ? age + 1 : age);
      ms = ns;
      e_in = pin; e_out = pout; e_err = perr; e_busy = (ns != M_IDLE);
      if (perr && m_errs < 255) m_errs++;
      hist_o.push_back(rd2o); if (hist_o.size() > DEB) void'(hist_o.pop_front());
      hist_i.push_back(rd2i); if (hist_i.size() > DEB) void'(hist_i.pop_front());
      if (hist_o.size() == DEB && count_diff(hist_o, m_do) == DEB) m_do = rd2o;
      if (hist_i.size() == DEB && count_diff(hist_i, m_di) == DEB) m_di = rd2i;
      rd2o = rd1o; rd1o = pad_outer;
      rd2i = rd1i; rd1i = pad_inner;
    end
  end

  int n_in = 0, n_out = 0, n_err = 0, n_busy = 0;
  int t_in = 0, t_out = 0, t_err = 0;

  // Per-cycle compare against the model, plus event bookkeeping for literal checks
  always @(negedge clk) begin
    if (started) begin
      check("pressure_in", int'(pressure_in), int'(e_in));
      check("pressure_out", int'(pressure_out), int'(e_out));
      check("seq_error", int'(seq_error), int'(e_err));
      check("busy", int'(busy), int'(e_busy));
`ifdef DOOR_PAD_ERRCNT_EN
      check("err_count", int'(err_count), m_errs);
`endif
      if (pressure_in)  begin n_in++;  t_in = cyc;  end
      if (pressure_out) begin n_out++; t_out = cyc; end
      if (seq_error)    begin n_err++; t_err = cyc; end
      if (busy) n_busy++;
    end
  end

  // ---------------- directed stimulus ----------------
  int t_set;
  int c_in, c_out, c_err, c_busy;

  task automatic apply(input bit o, input bit i, input int n);
    pad_outer = o;
    pad_inner = i;
    t_set = cyc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    c_in = n_in; c_out = n_out; c_err = n_err; c_busy = n_busy;
  endtask

  initial begin
    int t0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in", int'(pressure_in), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_err", int'(seq_error), 0);
    reset = 1'b0;
    apply(0, 0, 5);

    // Entry: pulse exactly 7 cycles after the final release
    snap();
    apply(1, 0, 20); apply(1, 1, 20); apply(0, 1, 20);
    apply(0, 0, 20); t0 = t_set;
    check("entry_count", n_in - c_in, 1);
    check("entry_latency", t_in - t0, 7);
    check("entry_no_out", n_out - c_out, 0);
    check("entry_busy_after", int'(busy), 0);

    // Exit
    snap();
    apply(0, 1, 20); apply(1, 1, 20); apply(1, 0, 20); apply(0, 0, 20);
    check("exit_count", n_out - c_out, 1);
    check("exit_no_in", n_in - c_in, 0);
    check("exit_no_err", n_err - c_err, 0);

    // Short glitches on outer never get through
    snap();
    for (int k = 0; k < 10; k++) begin
      apply(1, 0, 1 + (k % 3));
      apply(0, 0, 5);
    end
    check("glitch_busy", n_busy - c_busy, 0);

    // Outer held: timeout error 1032 cycles after the press
    snap();
    apply(1, 0, 2000); t0 = t_set;
    check("timeout_err", n_err - c_err, 1);
    check("timeout_latency", t_err - t0, 1032);
    check("timeout_busy", int'(busy), 1);
    apply(0, 0, 20);
    check("timeout_no_pulse", (n_in - c_in) + (n_out - c_out), 0);
    check("timeout_idle", int'(busy), 0);
`ifdef DOOR_PAD_ERRCNT_EN
    check("timeout_errcnt", int'(err_count), 1);
`endif

    // Both pads together from IDLE
    snap();
    apply(1, 1, 30); t0 = t_set;
    check("both_err", n_err - c_err, 1);
    check("both_latency", t_err - t0, 7);
    check("both_waitclr", int'(busy), 1);
    apply(0, 0, 20);
    check("both_idle", int'(busy), 0);

    // Illegal jump O1 -> inner only
    snap();
    apply(1, 0, 20); apply(0, 1, 20);
    check("jump_err", n_err - c_err, 1);
    check("jump_busy", int'(busy), 1);
    apply(0, 0, 20);
    check("jump_no_pulse", (n_in - c_in) + (n_out - c_out), 0);

    // Entry with backtracks, then an outer turnaround
    snap();
    apply(1, 0, 20); apply(1, 1, 20); apply(1, 0, 20); apply(1, 1, 20);
    apply(0, 1, 20); apply(1, 1, 20); apply(0, 1, 20); apply(0, 0, 20);
    apply(1, 0, 20); apply(0, 0, 20);
    check("backtrack_in", n_in - c_in, 1);
    check("backtrack_err", n_err - c_err, 0);

    // Exit with backtracks, then an inner turnaround
    snap();
    apply(0, 1, 20); apply(1, 1, 20); apply(0, 1, 20); apply(1, 1, 20);
    apply(1, 0, 20); apply(1, 1, 20); apply(1, 0, 20); apply(0, 0, 20);
    apply(0, 1, 20); apply(0, 0, 20);
    check("backtrack_out", n_out - c_out, 1);
    check("backtrack_out_err", n_err - c_err, 0);

    // Reset while in OB abandons the passage
    snap();
    apply(1, 0, 20); apply(1, 1, 20);
    check("ob_busy", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", int'(busy), 0);
    check("rst_in", int'(pressure_in), 0);
    check("rst_err", int'(seq_error), 0);
    reset = 1'b0;
    apply(1, 1, 2); apply(0, 0, 30);
    check("rst_no_pulse", (n_in - c_in) + (n_out - c_out), 0);
    check("rst_no_err", n_err - c_err, 0);

`ifdef DOOR_PAD_ERRCNT_EN
    // Saturation of the error counter
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 300; k++) begin
      apply(1, 1, 10);
      apply(0, 0, 10);
    end
    check("errcnt_sat", int'(err_count), 255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
